// File: rtl/alu_unit_if.sv
// Operand/result bundle between the execute-stage control and the registered ALU.
// The master drives operands and the operation select; the slave returns the registered result and flags.
interface alu_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             Negative;
  logic             Carry;
  logic             Overflow;

  modport master (
    output SrcA, SrcB, ALUControl,
    input  ALUResult, Zero, Negative, Carry, Overflow
  );

  modport slave (
    input  SrcA, SrcB, ALUControl,
    output ALUResult, Zero, Negative, Carry, Overflow
  );
endinterface

// File: rtl/alu_unit.sv
// Registered integer ALU for the RISC-V execute stage.
// Eight operations with result and Z/N/C/V flags, all captured after exactly one clock.
module alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  alu_unit_if.slave bus
);
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_PASS = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_SLTU = 3'b111;

  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             carry_sum;
  logic             carry_diff;
  logic             ovf_add;
  logic             ovf_sub;
  logic             lt_signed;
  logic             lt_unsigned;

  logic [WIDTH-1:0] result_next;
  logic             carry_next;
  logic             ovf_next;

  logic [WIDTH-1:0] result_reg;
  logic             zero_reg;
  logic             negative_reg;
  logic             carry_reg;
  logic             ovf_reg;

  assign src_a = bus.SrcA;
  assign src_b = bus.SrcB;

  // Subtraction shares the adder form A + ~B + 1 so carry-out is the inverted borrow.
  assign {carry_sum, sum}   = {1'b0, src_a} + {1'b0, src_b};
  assign {carry_diff, diff} = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};

  assign ovf_add = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
  assign ovf_sub = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);

  // Signed compare corrects the difference sign by overflow so mixed-sign extremes resolve.
  assign lt_signed   = diff[WIDTH-1] ^ ovf_sub;
  assign lt_unsigned = ~carry_diff;

  always_comb begin
    result_next = '0;
    carry_next  = 1'b0;
    ovf_next    = 1'b0;
    unique case (bus.ALUControl)
      OP_ADD: begin
        result_next = sum;
        carry_next  = carry_sum;
        ovf_next    = ovf_add;
      end
      OP_SUB: begin
        result_next = diff;
        carry_next  = carry_diff;
        ovf_next    = ovf_sub;
      end
      OP_AND:  result_next = src_a & src_b;
      OP_OR:   result_next = src_a | src_b;
      OP_PASS: result_next = src_b;
      OP_SLT:  result_next = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_XOR:  result_next = src_a ^ src_b;
      OP_SLTU: result_next = {{(WIDTH-1){1'b0}}, lt_unsigned};
      default: result_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_reg   <= '0;
      zero_reg     <= 1'b1;
      negative_reg <= 1'b0;
      carry_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      result_reg   <= result_next;
      zero_reg     <= (result_next == '0);
      negative_reg <= result_next[WIDTH-1];
      carry_reg    <= carry_next;
      ovf_reg      <= ovf_next;
    end
  end

  assign bus.ALUResult = result_reg;
  assign bus.Zero      = zero_reg;
  assign bus.Negative  = negative_reg;
  assign bus.Carry     = carry_reg;
  assign bus.Overflow  = ovf_reg;
endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vector table, async reset checks,
// and a randomized back-to-back stream against a plain-arithmetic reference model.
module tb_alu_unit;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  alu_unit_if #(.WIDTH(32)) bus ();

  alu_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } out_t;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  zncv;
  } vec_t;

  // Reference computed from the arithmetic meaning of each operation.
  function automatic out_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    out_t        o;
    longint      sa;
    longint      sb;
    longint      sv;
    logic [63:0] us;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    o.res = 32'h0;
    o.c   = 1'b0;
    o.v   = 1'b0;
    case (op)
      3'd0: begin
        us    = {32'h0, a} + {32'h0, b};
        o.res = us[31:0];
        o.c   = (us > 64'h0000_0000_FFFF_FFFF);
        sv    = sa + sb;
        o.v   = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      3'd1: begin
        o.res = a - b;
        o.c   = (a >= b);
        sv    = sa - sb;
        o.v   = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      3'd2: o.res = a & b;
      3'd3: o.res = a | b;
      3'd4: o.res = b;
      3'd5: o.res = (sa < sb) ? 32'd1 : 32'd0;
      3'd6: o.res = a ^ b;
      default: o.res = (a < b) ? 32'd1 : 32'd0;
    endcase
    o.z = (o.res == 32'h0);
    o.n = o.res[31];
    return o;
  endfunction

  task automatic check_out(input string name, input logic [31:0] res, input logic [3:0] zncv);
    logic [3:0] got;
    got = {bus.Zero, bus.Negative, bus.Carry, bus.Overflow};
    checks++;
    if (bus.ALUResult !== res) begin
      failures++;
      $display("FAIL %s result got=%08h want=%08h", name, bus.ALUResult, res);
    end
    checks++;
    if (got !== zncv) begin
      failures++;
      $display("FAIL %s flags(ZNCV) got=%04b want=%04b", name, got, zncv);
    end
    $display("txn %-14s op=%0d a=%08h b=%08h res=%08h zncv=%04b", name,
             bus.ALUControl, bus.SrcA, bus.SrcB, bus.ALUResult, got);
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.ALUControl = op;
    bus.SrcA       = a;
    bus.SrcB       = b;
  endtask

  vec_t vecs[$];
  out_t m;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    drive(3'd0, 32'h0, 32'h0);

    vecs.push_back('{"add",        3'd0, 32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 4'b0000});
    vecs.push_back('{"sub",        3'd1, 32'h0000_00FF, 32'h0000_00F0, 32'h0000_000F, 4'b0010});
    vecs.push_back('{"and",        3'd2, 32'h0000_00FF, 32'h0000_0F0F, 32'h0000_000F, 4'b0000});
    vecs.push_back('{"or",         3'd3, 32'h0000_00FF, 32'h0000_0F0F, 32'h0000_0FFF, 4'b0000});
    vecs.push_back('{"xor",        3'd6, 32'h0000_00FF, 32'h0000_0F0F, 32'h0000_0FF0, 4'b0000});
    vecs.push_back('{"pass",       3'd4, 32'h0000_00FF, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 4'b0100});
    vecs.push_back('{"slt_2_1",    3'd5, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 4'b1000});
    vecs.push_back('{"slt_negb",   3'd5, 32'h0000_0001, 32'hF0F0_0002, 32'h0000_0000, 4'b1000});
    vecs.push_back('{"sltu_negb",  3'd7, 32'h0000_0001, 32'hF0F0_0002, 32'h0000_0001, 4'b0000});
    vecs.push_back('{"add_ovf",    3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101});
    vecs.push_back('{"sub_ovf",    3'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0011});
    vecs.push_back('{"slt_min_max",3'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0000});
    vecs.push_back('{"slt_max_min",3'd5, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 4'b1000});
    vecs.push_back('{"slt_m1_1",   3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0000});
    vecs.push_back('{"add_wrap",   3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010});
    vecs.push_back('{"sub_eq",     3'd1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b1010});
    vecs.push_back('{"sub_borrow", 3'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b0100});
    vecs.push_back('{"sltu_eq",    3'd7, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b1000});

    // Async reset with no clock edge involved (first posedge is at t=5).
    #1 reset = 1'b1;
    #1 check_out("reset_async", 32'h0, 4'b1000);
    @(posedge clk);
    #1 reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      @(posedge clk);
      #1 check_out(vecs[i].name, vecs[i].res, vecs[i].zncv);
    end

    // Output must not move before the next edge even when inputs change.
    drive(3'd0, 32'h1234_0000, 32'h0000_5678);
    #2 check_out("hold", 32'h0000_0000, 4'b1000);
    @(posedge clk);
    #1 check_out("after_hold", 32'h1234_5678, 4'b0000);

    // Back-to-back random stream with a reset pulse in the middle.
    for (int k = 0; k < 300; k++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: b = 32'h7FFF_FFFF;
        2: b = a;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      drive(op, a, b);
      @(posedge clk);
      #1;
      m = model(op, a, b);
      check_out("rand", m.res, {m.z, m.n, m.c, m.v});
      if (k == 150) begin
        reset = 1'b1;
        #1 check_out("reset_mid", 32'h0, 4'b1000);
        @(posedge clk);
        #1 check_out("reset_held", 32'h0, 4'b1000);
        reset = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end
endmodule
